// File: rtl/cjb_input_conditioner.sv
// rtl/cjb_input_conditioner.sv - synchronizes, debounces and edge-detects board push-button and switches
// Optional macro CJB_SW_DEBOUNCE_EN: debounce the switches too (otherwise they are only synchronized).
module cjb_input_conditioner #(
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int CNT_W        = 20,
  parameter int SW_W         = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pb_raw_i,
  input  logic [SW_W-1:0] sw_raw_i,
  input  logic            ack_i,
  output logic            pb_level_o,
  output logic            pb_press_o,
  output logic            pb_pending_o,
  output logic            pb_overrun_o,
  output logic [SW_W-1:0] sw_stable_o,
  output logic            sw_change_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             pb_meta_q, pb_sync_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic             pb_stable_q, pb_stable_d;
  logic [CNT_W-1:0] pb_cnt_q, pb_cnt_d;
  logic             pb_level_prev_q, pb_press_q;
  logic             pb_pending_q, pb_pending_d;
  logic             pb_overrun_q, pb_overrun_d;
  logic [SW_W-1:0]  sw_stable_w, sw_prev_q;
  logic             sw_change_q;

  // Button synchronizer idles at 1 because the pin is active-low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pb_meta_q <= 1'b1;
      pb_sync_q <= 1'b1;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      pb_meta_q <= pb_raw_i;
      pb_sync_q <= pb_meta_q;
      sw_meta_q <= sw_raw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    pb_stable_d = pb_stable_q;
    pb_cnt_d    = '0;
    if (pb_sync_q != pb_stable_q) begin
      if (pb_cnt_q == CNT_LAST) begin
        pb_stable_d = pb_sync_q;
      end else begin
        pb_cnt_d = pb_cnt_q + CNT_W'(1);
      end
    end
  end

  // A press arriving together with ack still leaves a press pending, but the overrun is forgiven.
  always_comb begin
    pb_pending_d = pb_press_q | (pb_pending_q & ~ack_i);
    pb_overrun_d = ack_i ? 1'b0 : (pb_overrun_q | (pb_press_q & pb_pending_q));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pb_stable_q     <= 1'b1;
      pb_cnt_q        <= '0;
      pb_level_prev_q <= 1'b0;
      pb_press_q      <= 1'b0;
      pb_pending_q    <= 1'b0;
      pb_overrun_q    <= 1'b0;
    end else begin
      pb_stable_q     <= pb_stable_d;
      pb_cnt_q        <= pb_cnt_d;
      pb_level_prev_q <= ~pb_stable_q;
      pb_press_q      <= ~pb_stable_q & ~pb_level_prev_q;
      pb_pending_q    <= pb_pending_d;
      pb_overrun_q    <= pb_overrun_d;
    end
  end

`ifdef CJB_SW_DEBOUNCE_EN
  logic [SW_W-1:0]            sw_stable_q, sw_stable_d;
  logic [SW_W-1:0][CNT_W-1:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (sw_sync_q[i] != sw_stable_q[i]) begin
        if (sw_cnt_q[i] == CNT_LAST) begin
          sw_stable_d[i] = sw_sync_q[i];
        end else begin
          sw_cnt_d[i] = sw_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_stable_q <= '0;
      sw_cnt_q    <= '0;
    end else begin
      sw_stable_q <= sw_stable_d;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  assign sw_stable_w = sw_stable_q;
`else
  assign sw_stable_w = sw_sync_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_prev_q   <= '0;
      sw_change_q <= 1'b0;
    end else begin
      sw_prev_q   <= sw_stable_w;
      sw_change_q <= (sw_stable_w != sw_prev_q);
    end
  end

  assign pb_level_o   = ~pb_stable_q;
  assign pb_press_o   = pb_press_q;
  assign pb_pending_o = pb_pending_q;
  assign pb_overrun_o = pb_overrun_q;
  assign sw_stable_o  = sw_stable_w;
  assign sw_change_o  = sw_change_q;

endmodule

// File: tb/tb_cjb_input_conditioner.sv
// tb/tb_cjb_input_conditioner.sv - randomized and directed checks of cjb_input_conditioner against a window-based model
// Honours CJB_SW_DEBOUNCE_EN in the same way as the design.
module tb_cjb_input_conditioner;
  localparam int D    = 4;
  localparam int SW_W = 4;
`ifdef CJB_SW_DEBOUNCE_EN
  localparam int SW_LAT = 2 + D;
`else
  localparam int SW_LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pb_raw = 1'b1;
  logic [SW_W-1:0] sw_raw = '0;
  logic            ack = 1'b0;
  logic            pb_level, pb_press, pb_pending, pb_overrun, sw_change;
  logic [SW_W-1:0] sw_stable;

  int vectors = 0;
  int miscompares = 0;

  cjb_input_conditioner #(.DEBOUNCE_CNT(D), .CNT_W(3), .SW_W(SW_W)) dut (
    .clk_i(clk), .rst_i(rst), .pb_raw_i(pb_raw), .sw_raw_i(sw_raw), .ack_i(ack),
    .pb_level_o(pb_level), .pb_press_o(pb_press), .pb_pending_o(pb_pending),
    .pb_overrun_o(pb_overrun), .sw_stable_o(sw_stable), .sw_change_o(sw_change)
  );

  always #5 clk = ~clk;

  // Model: bit SW_W is the button (stored as raw polarity), bits below are switches.
  logic [SW_W:0] m_raw_hist[$];
  logic [SW_W:0] m_syn_hist[$];
  logic [SW_W:0] m_st, m_old;
  logic          m_press, m_pending, m_overrun, m_chg, m_rose, m_moved;
  logic          all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_raw_hist.delete();
      m_raw_hist.push_back({1'b1, {SW_W{1'b0}}});
      m_raw_hist.push_back({1'b1, {SW_W{1'b0}}});
      m_syn_hist.delete();
      m_st = {1'b1, {SW_W{1'b0}}};
      {m_press, m_pending, m_overrun, m_chg, m_rose, m_moved} = '0;
    end else begin
      m_pending = m_press ? 1'b1 : (ack ? 1'b0 : m_pending);
      m_overrun = (m_press && m_pending_before_edge() && !ack) ? 1'b1 : (ack ? 1'b0 : m_overrun);
      m_press = m_rose;
      m_chg = m_moved;
      m_old = m_st;
      m_syn_hist.push_back(m_raw_hist.pop_front());
      m_raw_hist.push_back({pb_raw, sw_raw});
      if (m_syn_hist.size() > D) void'(m_syn_hist.pop_front());
      // A bit flips once its last D synchronized samples all disagree with it.
      for (int b = 0; b <= SW_W; b++) begin
        all_diff = (m_syn_hist.size() == D);
        foreach (m_syn_hist[j]) if (m_syn_hist[j][b] == m_st[b]) all_diff = 1'b0;
        if (all_diff) m_st[b] = ~m_st[b];
      end
`ifndef CJB_SW_DEBOUNCE_EN
      m_st[SW_W-1:0] = m_raw_hist[0][SW_W-1:0];
`endif
      m_rose  = !m_st[SW_W] && m_old[SW_W];
      m_moved = (m_st[SW_W-1:0] != m_old[SW_W-1:0]);
    end
  end

  // Pending as it stood before this edge; captured each edge ahead of the update above.
  logic m_pend_prev = 1'b0;
  always @(negedge clk) m_pend_prev = m_pending;
  function automatic logic m_pending_before_edge();
    return m_pend_prev;
  endfunction

  logic [8:0] obs, expv;
  assign obs  = {pb_level, pb_press, pb_pending, pb_overrun, sw_stable, sw_change};
  assign expv = {~m_st[SW_W], m_press, m_pending, m_overrun, m_st[SW_W-1:0], m_chg};

  task automatic test_reset();
    rst = 1'b1; pb_raw = 1'($urandom); sw_raw = SW_W'($urandom); ack = 1'($urandom);
    #1;
    vectors++;
    if (obs !== 9'h0) begin miscompares++; $display("FAIL reset_async: got %h expected 000", obs); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 9'h0) begin miscompares++; $display("FAIL reset_held: got %h expected 000", obs); end
      pb_raw = 1'($urandom); sw_raw = SW_W'($urandom); ack = 1'($urandom);
    end
    pb_raw = 1'b1; sw_raw = '0; ack = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 9'h0 || expv !== 9'h0) begin
        miscompares++; $display("FAIL reset_idle: got %h model %h expected 000", obs, expv);
      end
    end
  endtask

  task automatic test_clean_press();
    int lvl_at = -1, press_at = -1, pend_at = -1, npress = 0;
    pb_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL press_model: got %h expected %h", obs, expv); end
      if (pb_level && lvl_at < 0) lvl_at = i;
      if (pb_press) begin npress++; if (press_at < 0) press_at = i; end
      if (pb_pending && pend_at < 0) pend_at = i;
    end
    vectors++;
    if (lvl_at != 6 || press_at != 7 || pend_at != 8 || npress != 1) begin
      miscompares++;
      $display("FAIL press_timing: got level@%0d press@%0d pending@%0d presses=%0d expected 6 7 8 1",
               lvl_at, press_at, pend_at, npress);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++;
    if ({pb_pending, pb_overrun} !== 2'b00) begin
      miscompares++; $display("FAIL press_ack: got %b expected 00", {pb_pending, pb_overrun});
    end
    pb_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv || pb_press) begin miscompares++; $display("FAIL release: got %h expected %h", obs, expv); end
    end
  endtask

  task automatic test_bounce();
    int lvl_at = -1, npress = 0;
    pb_raw = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL bounce_model: got %h expected %h", obs, expv); end
      if (pb_level && lvl_at < 0) lvl_at = i;
      if (pb_press) npress++;
      pb_raw = (i + 1 == 4);
    end
    vectors++;
    if (lvl_at != 10 || npress != 1) begin
      miscompares++; $display("FAIL bounce_timing: got level@%0d presses=%0d expected 10 1", lvl_at, npress);
    end
    ack = 1'b1; pb_raw = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overrun();
    logic found = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pb_raw = p[0];
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        vectors++;
        if (obs !== expv) begin miscompares++; $display("FAIL overrun_model: got %h expected %h", obs, expv); end
      end
    end
    vectors++;
    if ({pb_pending, pb_overrun} !== 2'b11) begin
      miscompares++; $display("FAIL overrun_set: got %b expected 11", {pb_pending, pb_overrun});
    end
    pb_raw = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (pb_press) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL third_press: got no pulse expected pulse within 12 cycles"); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++;
    if ({pb_pending, pb_overrun} !== 2'b10 || obs !== expv) begin
      miscompares++; $display("FAIL press_with_ack: got %b expected 10", {pb_pending, pb_overrun});
    end
    ack = 1'b1; pb_raw = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_switches();
    int st_at = -1, nchg = 0, chg_at = -1;
    sw_raw = 4'b1010;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL sw_model: got %h expected %h", obs, expv); end
      if (sw_stable == 4'b1010 && st_at < 0) st_at = i;
      if (sw_change) begin nchg++; chg_at = i; end
    end
    vectors++;
    if (st_at != SW_LAT || nchg != 1 || chg_at != SW_LAT + 1) begin
      miscompares++;
      $display("FAIL sw_timing: got stable@%0d changes=%0d change@%0d expected %0d 1 %0d",
               st_at, nchg, chg_at, SW_LAT, SW_LAT + 1);
    end
    sw_raw = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int lvl_at = -1;
    pb_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 9'h0) begin miscompares++; $display("FAIL mid_reset: got %h expected 000", obs); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL mid_model: got %h expected %h", obs, expv); end
      if (pb_level && lvl_at < 0) lvl_at = i;
    end
    vectors++;
    if (lvl_at != 6) begin miscompares++; $display("FAIL mid_latency: got level@%0d expected 6", lvl_at); end
    ack = 1'b1; pb_raw = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL random[%0d]: got %h expected %h", i, obs, expv); end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) pb_raw = ~pb_raw;
      if ($urandom_range(0, 7) == 0) sw_raw[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      ack = ($urandom_range(0, 4) == 0);
    end
    rst = 1'b0; ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_overrun();
    test_switches();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cjb_input_conditioner.md
# cjb_input_conditioner

Input-side conditioning block for the RISC CPU's board I/O. It takes the raw, asynchronous, bouncing push-button and slide-switch signals and produces stable levels for the CPU's input port. It also produces single-cycle edge pulses and a sticky "button pressed" flag that the CPU clears with an acknowledge handshake. It sits between the board pins (pb[1], sw[3:0]) and the processor's memory-mapped input port, and runs on the same clock as the processor.

## Interface
- DEBOUNCE_CNT, default 1000000: number of consecutive cycles a synchronized input must differ from its stable value before the stable value updates. Legal range is at least 2.
- CNT_W, default 20: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CNT.
- SW_W, default 4: number of slide switches.
- Clock  input  1  single clock for all logic; rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- pb_raw  input  1  raw push-button; active-low (0 = pressed).
- sw_raw  input  SW_W  raw slide switches; 1 = up.
- ack  input  1  CPU read-acknowledge; when high for one cycle, it clears pb_pending and pb_overrun.
- pb_level  output  1  debounced button state; 1 = pressed.
- pb_press  output  1  one-cycle pulse on the debounced press edge.
- pb_pending  output  1  sticky flag: a press has occurred and has not yet been acknowledged.
- pb_overrun  output  1  sticky flag: a press occurred while pb_pending was already set.
- sw_stable  output  SW_W  debounced switch levels.
- sw_change  output  1  one-cycle pulse whenever any bit of sw_stable changes.

## Operation
- **Synchronizers.** Each raw input passes through a 2-FF synchronizer.
  - The pb synchronizer resets to 1 (released).
  - The sw synchronizers reset to 0.
- **Debounce.** Each input bit has its own stable register and its own CNT_W counter.
  - In any cycle where the synchronized value equals the stable value, the counter is cleared.
  - In any cycle where they differ, the counter increments.
  - When they differ and the counter equals DEBOUNCE_CNT-1, the stable value takes the synchronized value and the counter clears.
  - A single-cycle glitch shorter than DEBOUNCE_CNT cycles never reaches the stable value.
- **pb_level** is the inverse of the pb stable register.
- **pb_press** is high for exactly one cycle, in the cycle after pb_level goes 0→1. Releases produce no pulse.
- **pb_pending**:
  - Set by pb_press.
  - Cleared by ack.
  - If pb_press and ack occur in the same cycle, pb_pending stays 1 (set wins).
- **pb_overrun**:
  - Set when pb_press occurs while pb_pending=1 and ack=0.
  - Cleared by ack.
  - If pb_press, pb_pending=1 and ack=1 occur in the same cycle, pb_overrun ends at 0, because the earlier press was acknowledged.
- **sw_change** is high for one cycle, in the cycle after any sw_stable bit changes. Simultaneous changes on several bits produce a single pulse.
- **ack when nothing is pending** has no effect other than clearing the (already 0) flags.

## Timing
- **Reset values (all outputs):** pb_level=0, pb_press=0, pb_pending=0, pb_overrun=0, sw_stable=0, sw_change=0. All counters are 0.
- **Button latency:** a clean raw pb transition reaches pb_level 2+DEBOUNCE_CNT cycles after the first clock edge that samples it. pb_press follows one cycle later. pb_pending is visible in the same cycle as pb_press... no: pb_pending rises one cycle after pb_press is asserted (registered).
- **Switch latency:** sw_stable follows the same 2+DEBOUNCE_CNT rule. sw_change follows sw_stable by one cycle.
- **Reset asserted mid-debounce:** everything returns to reset values immediately (asynchronously). A partial count is discarded.
- **Switch held up through reset:** after reset releases, that sw_stable bit rises 2+DEBOUNCE_CNT cycles later and emits a sw_change pulse. This is the intended power-up behaviour.
- **Counter wrap:** the counter cannot wrap, because it clears at DEBOUNCE_CNT-1.

## Configuration
- **CJB_SW_DEBOUNCE_EN defined:** switches use the debounce logic described above.
- **CJB_SW_DEBOUNCE_EN undefined:**
  - The switch counters are removed.
  - sw_stable is the 2-FF synchronizer output directly, with latency 2 cycles.
  - sw_change is still a one-cycle pulse, one cycle after any sw_stable change.
  - The push-button path is always debounced, regardless of this macro.

## Test plan
All scenarios use DEBOUNCE_CNT=4 and SW_W=4.
- **Reset:** Reset=1 with random inputs → all outputs 0. Release Reset with pb_raw=1, sw_raw=0 → outputs remain 0 for 20 cycles.
- **Clean press:** pb_raw 1→0, held → pb_level=1 exactly 6 cycles later, pb_press one-cycle pulse at cycle 7, pb_pending=1 from cycle 8 until ack.
- **Bounce rejection:** pb_raw low for 3 cycles, high for 1, then low steadily → no pb_level change until 4 consecutive differing synchronized cycles. Exactly one pb_press.
- **Overrun:** two presses without ack → pb_overrun=1. Third press coincident with ack → pb_pending=1, pb_overrun=0.
- **Switches:** sw_raw 0000→1010 → sw_stable=1010 after 6 cycles, and a single sw_change pulse. With the macro undefined → sw_stable=1010 after 2 cycles.
- **Reset mid-debounce:** Reset pulsed 2 cycles after a pb_raw fall → pb_level stays 0, then rises 6 cycles after Reset deasserts.
